// File: rtl/codon_writer.sv
// Codon RAM writer: packs a valid/ready nibble stream into F-terminated codons
// and closes the list with an extra F.
module codon_writer #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned MAX_NIB = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        nib_in,
  input  logic              nib_valid,
  input  logic              nib_last,
  output logic              nib_ready,
  input  logic              gene_end,
  output logic              we_wr,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [3:0]        din_wr,
  output logic              done_wr,
  output logic              full,
  output logic              len_err,
  output logic [ADDR_W-1:0] codon_cnt
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned NCNT_W = $clog2(MAX_NIB + 1);

  // Last address that may take data: keeps two slots for terminator + final F.
  localparam logic [ADDR_W-1:0] PTR_LIM  = ADDR_W'(DEPTH - 3);
  localparam logic [NCNT_W-1:0] NCNT_MAX = NCNT_W'(MAX_NIB);
  localparam logic [3:0]        NIB_F    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_TERM,
    S_FIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [NCNT_W-1:0]   ncnt_q, ncnt_d;
  logic [NCNT_W-1:0]   ncnt_inc_c;
  logic [ADDR_W-1:0]   codon_cnt_d;
  logic                len_err_d;
  logic                done_d;
  logic                wr_c;
  logic [3:0]          wr_data_c;
  logic                room_c;
  logic                accept_c;
  logic                is_mark_c;

  assign room_c     = (ptr_q <= PTR_LIM);
  assign accept_c   = nib_valid && nib_ready;
  assign is_mark_c  = (nib_in == NIB_F);
  assign ncnt_inc_c = ncnt_q + NCNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; start overrides every state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_ACCEPT;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (accept_c) begin
            if (!is_mark_c) begin
              if (nib_last || (ncnt_inc_c == NCNT_MAX)) state_d = S_TERM;
            end else if (ncnt_q != '0) begin
              state_d = S_TERM;
            end
          end else if (gene_end) begin
            state_d = (ncnt_q != '0) ? S_TERM : S_FIN;
          end
        end
        S_TERM:  state_d = S_ACCEPT;
        S_FIN:   state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake flags, RAM write request and datapath next values
  always_comb begin
    nib_ready   = (state_q == S_ACCEPT) && room_c;
    full        = (state_q == S_ACCEPT) && !room_c;
    ptr_d       = ptr_q;
    ncnt_d      = ncnt_q;
    codon_cnt_d = codon_cnt;
    len_err_d   = len_err;
    done_d      = done_wr;
    wr_c        = 1'b0;
    wr_data_c   = NIB_F;
    if (start) begin
      ptr_d       = '0;
      ncnt_d      = '0;
      codon_cnt_d = '0;
      len_err_d   = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          // An F nibble is an in-band close marker and is never stored
          if (accept_c && !is_mark_c) begin
            wr_c      = 1'b1;
            wr_data_c = nib_in;
            ptr_d     = ptr_q + ADDR_W'(1);
            ncnt_d    = ncnt_inc_c;
            if ((ncnt_inc_c == NCNT_MAX) && !nib_last) len_err_d = 1'b1;
          end
        end
        S_TERM: begin
          wr_c        = 1'b1;
          ptr_d       = ptr_q + ADDR_W'(1);
          ncnt_d      = '0;
          codon_cnt_d = codon_cnt + ADDR_W'(1);
        end
        S_FIN:   wr_c   = 1'b1;
        S_DONE:  done_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath and registered RAM port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      ncnt_q    <= '0;
      codon_cnt <= '0;
      len_err   <= 1'b0;
      done_wr   <= 1'b0;
      we_wr     <= 1'b0;
      addr_wr   <= '0;
      din_wr    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      ncnt_q    <= ncnt_d;
      codon_cnt <= codon_cnt_d;
      len_err   <= len_err_d;
      done_wr   <= done_d;
      we_wr     <= wr_c;
      if (wr_c) begin
        addr_wr <= ptr_q;
        din_wr  <= wr_data_c;
      end
    end
  end

endmodule

// File: tb/tb_codon_writer.sv
// Randomized and directed bench for codon_writer against a procedural
// list-building model and the expected RAM images.
module tb_codon_writer;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned MAX_NIB = 5;
  localparam int          DEPTH   = 32;

  localparam int P_IDLE = 0;
  localparam int P_ACC  = 1;
  localparam int P_TERM = 2;
  localparam int P_FIN  = 3;
  localparam int P_DONE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        nib_in = 4'h0;
  logic              nib_valid = 1'b0;
  logic              nib_last = 1'b0;
  logic              gene_end = 1'b0;
  logic              nib_ready;
  logic              we_wr;
  logic [ADDR_W-1:0] addr_wr;
  logic [3:0]        din_wr;
  logic              done_wr;
  logic              full;
  logic              len_err;
  logic [ADDR_W-1:0] codon_cnt;

  codon_writer #(.ADDR_W(ADDR_W), .MAX_NIB(MAX_NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .nib_in(nib_in),
    .nib_valid(nib_valid), .nib_last(nib_last), .nib_ready(nib_ready),
    .gene_end(gene_end), .we_wr(we_wr), .addr_wr(addr_wr), .din_wr(din_wr),
    .done_wr(done_wr), .full(full), .len_err(len_err), .codon_cnt(codon_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model of the list being built
  int ph = P_IDLE;
  int m_ptr = 0, m_ncnt = 0, m_cnt = 0, m_addr = 0, m_din = 0;
  bit m_err = 0, m_done = 0, m_we = 0;
  int ram [DEPTH];
  int we_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; m_ptr = 0; m_ncnt = 0; m_cnt = 0; m_addr = 0; m_din = 0;
    m_err = 0; m_done = 0; m_we = 0;
  endtask

  // One clock: predict, check flags before the edge, check registers after it
  task automatic step();
    bit rdy, fl, wr;
    int wa, wd;
    rdy = (ph == P_ACC) && (m_ptr <= DEPTH - 3);
    fl  = (ph == P_ACC) && (m_ptr > DEPTH - 3);
    check("nib_ready", nib_ready, rdy);
    check("full", full, fl);
    wr = 0; wa = 0; wd = 0;
    if (start) begin
      ph = P_ACC; m_ptr = 0; m_ncnt = 0; m_cnt = 0; m_err = 0; m_done = 0;
    end else begin
      case (ph)
        P_ACC: begin
          if (nib_valid && rdy) begin
            if (nib_in != 4'hF) begin
              wr = 1; wa = m_ptr; wd = int'(nib_in);
              m_ptr++; m_ncnt++;
              if (m_ncnt == MAX_NIB && !nib_last) m_err = 1;
              if (nib_last || m_ncnt == MAX_NIB) ph = P_TERM;
            end else if (m_ncnt > 0) begin
              ph = P_TERM;
            end
          end else if (gene_end) begin
            ph = (m_ncnt > 0) ? P_TERM : P_FIN;
          end
        end
        P_TERM: begin
          wr = 1; wa = m_ptr; wd = 15; m_ptr++; m_ncnt = 0; m_cnt++; ph = P_ACC;
        end
        P_FIN: begin
          wr = 1; wa = m_ptr; wd = 15; ph = P_DONE;
        end
        P_DONE: m_done = 1;
        default: ;
      endcase
    end
    m_we = wr;
    if (wr) begin m_addr = wa; m_din = wd; end
    @(posedge clk);
    #1;
    check("we_wr", we_wr, m_we);
    check("addr_wr", addr_wr, m_addr);
    check("din_wr", din_wr, m_din);
    check("done_wr", done_wr, m_done);
    check("len_err", len_err, m_err);
    check("codon_cnt", codon_cnt, m_cnt);
    if (we_wr === 1'b1) begin
      ram[addr_wr] = int'(din_wr);
      we_count++;
    end
  endtask

  task automatic do_start();
    foreach (ram[i]) ram[i] = -1;
    we_count = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    bit acc;
    acc = 0;
    nib_in = d; nib_last = last; nib_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc = (ph == P_ACC) && (m_ptr <= DEPTH - 3);
      step();
      if (acc) break;
    end
    check("send_accepted", acc, 1);
    nib_valid = 1'b0; nib_last = 1'b0;
  endtask

  task automatic close_list();
    gene_end = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ph == P_DONE) break;
    end
    step();
    gene_end = 1'b0;
    check("list_done", done_wr, 1);
  endtask

  task automatic check_ram(input string tag, input int exp_q[$]);
    foreach (exp_q[i]) check(tag, ram[i], exp_q[i]);
    check({tag, "_writes"}, we_count, exp_q.size());
  endtask

  initial begin
    int exp_q[$];
    foreach (ram[i]) ram[i] = -1;
    model_reset();

    // reset values
    #3;
    check("rst_we", we_wr, 0);
    check("rst_addr", addr_wr, 0);
    check("rst_din", din_wr, 0);
    check("rst_done", done_wr, 0);
    check("rst_err", len_err, 0);
    check("rst_cnt", codon_cnt, 0);
    check("rst_ready", nib_ready, 0);
    check("rst_full", full, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // two terminated codons then close
    do_start();
    send(4'h1, 0); send(4'h2, 0); send(4'h3, 1);
    send(4'hA, 0); send(4'hB, 1);
    close_list();
    exp_q = {1, 2, 3, 15, 10, 11, 15, 15};
    check_ram("t1_ram", exp_q);
    check("t1_cnt", codon_cnt, 2);

    // forced close at MAX_NIB
    do_start();
    for (int k = 1; k <= 5; k++) send(4'(k), 0);
    check("t2_bubble", nib_ready, 0);
    send(4'h6, 0);
    close_list();
    exp_q = {1, 2, 3, 4, 5, 15, 6, 15, 15};
    check_ram("t2_ram", exp_q);
    check("t2_len_err", len_err, 1);

    // leading F dropped, F closes a codon, gene_end closes an open codon
    do_start();
    send(4'hF, 0); send(4'h7, 0); send(4'hF, 0); send(4'h9, 0);
    close_list();
    exp_q = {7, 15, 9, 15, 15};
    check_ram("t3_ram", exp_q);
    check("t3_cnt", codon_cnt, 2);

    // fill with 1-nibble codons until full
    do_start();
    for (int k = 0; k < 15; k++) send(4'((k % 14) + 1), 1);
    step();
    check("t4_full", full, 1);
    check("t4_ready", nib_ready, 0);
    nib_in = 4'h3; nib_valid = 1'b1;
    step(); step();
    nib_valid = 1'b0;
    close_list();
    exp_q = {};
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back((k % 14) + 1);
      exp_q.push_back(15);
    end
    exp_q.push_back(15);
    check_ram("t4_ram", exp_q);
    check("t4_last_addr", addr_wr, 30);

    // start during TERM abandons the terminator
    do_start();
    send(4'h1, 0); send(4'h2, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t5_no_we", we_wr, 0);
    check("t5_cnt", codon_cnt, 0);
    send(4'h3, 1);
    check("t5_addr", addr_wr, 0);
    check("t5_din", din_wr, 3);
    step();

    // asynchronous reset mid-write
    do_start();
    send(4'h5, 0);
    check("t6_we_pre", we_wr, 1);
    rst = 1'b0;
    #1;
    check("t6_we", we_wr, 0);
    check("t6_addr", addr_wr, 0);
    check("t6_din", din_wr, 0);
    check("t6_cnt", codon_cnt, 0);
    check("t6_ready", nib_ready, 0);
    model_reset();
    #3 rst = 1'b1;
    nib_in = 4'h4; nib_valid = 1'b1;
    for (int k = 0; k < 3; k++) step();
    nib_valid = 1'b0;

    // random traffic: short lists, then long lists that reach full
    for (int seg = 0; seg < 2; seg++) begin
      do_start();
      for (int c = 0; c < 2000; c++) begin
        start     = ($urandom_range(0, 99) < 2) || (ph == P_DONE && $urandom_range(0, 3) == 0);
        nib_valid = ($urandom_range(0, 3) != 0);
        nib_in    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        nib_last  = ($urandom_range(0, 2) == 0);
        gene_end  = (seg == 0) ? ($urandom_range(0, 99) < 8) : ($urandom_range(0, 999) < 5);
        step();
      end
      start = 1'b0; nib_valid = 1'b0; gene_end = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/codon_writer.md
# codon_writer

Writer side of the codon memory. It accepts a stream of 4-bit gene nibbles over a valid/ready handshake and packs them into the codon RAM in the format the codon reader consumes. Each codon is written as 1–`MAX_NIB` non-`F` nibbles followed by a `4'hF` terminator, and the list ends with one extra `4'hF`. It sits between the gene source and the write port of the codon RAM, whose read port feeds the codon reader.

## Interface
- `ADDR_W`, default 5: codon RAM address width; `DEPTH = 2**ADDR_W`.
- `MAX_NIB`, default 5: maximum data nibbles per codon, excluding the terminator.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: pulse; begins a new list at address 0 and clears flags.
- `nib_in` input 4: gene nibble.
- `nib_valid` input 1: `nib_in` is valid.
- `nib_last` input 1: with `nib_valid`, marks the last nibble of the codon.
- `nib_ready` output 1: block can accept a nibble this cycle.
- `gene_end` input 1: level request to close the list; held until `done_wr`.
- `we_wr` output 1: RAM write enable, registered.
- `addr_wr` output `ADDR_W`: RAM write address, registered.
- `din_wr` output 4: RAM write data, registered.
- `done_wr` output 1: list fully written, final `F` included; held until `start`.
- `full` output 1: no room for another data nibble.
- `len_err` output 1: sticky; a codon was force-closed at `MAX_NIB` nibbles without `nib_last`.
- `codon_cnt` output `ADDR_W`: number of codon terminators written.

## Operation
- Internal state: write pointer `ptr` (`ADDR_W` bits) and open-codon nibble count `ncnt` (0..`MAX_NIB`).
- States: `IDLE`, `ACCEPT`, `TERM`, `FIN`, `DONE`.
- `start` has priority in every state. On `start`: `ptr`=0, `ncnt`=0, `codon_cnt`=0, `len_err`=0, `done_wr`=0, next state `ACCEPT`.
- `nib_ready` = (state==`ACCEPT`) && (`ptr` <= `DEPTH`-3). This reserves room for the terminator and the final `F`, so an open codon is always closable.
- `full` = (state==`ACCEPT`) && (`ptr` > `DEPTH`-3).
- Accept = `nib_valid` && `nib_ready`.
- Accept with `nib_in` != `F`:
  - Write `nib_in` at `ptr`; `ptr`++; `ncnt`++.
  - If `nib_last` or the new `ncnt`==`MAX_NIB`, go to `TERM`.
  - If `ncnt` reaches `MAX_NIB` without `nib_last`, set `len_err`.
- Accept with `nib_in`==`F` (an in-band end marker; it is never written as data):
  - If `ncnt`>0, go to `TERM` with no write this cycle.
  - If `ncnt`==0, the nibble is consumed and dropped.
- `ACCEPT`, no accept this cycle, `gene_end`=1:
  - If `ncnt`>0, go to `TERM`, then `ACCEPT`; `gene_end` is re-honored there.
  - Else go to `FIN`.
- `TERM`: write `F` at `ptr`; `ptr`++; `ncnt`=0; `codon_cnt`++; go to `ACCEPT`. `nib_ready`=0.
- `FIN`: write `F` at `ptr`; go to `DONE`. `nib_ready`=0.
- `DONE`: `done_wr`=1, no writes; waits for `start`.
- `IDLE`: reset state; `nib_ready`=0; waits for `start`.
- Empty codons are never written, so a bare `F` only ever appears as a terminator or the final mark.
- A full RAM with no open codon leaves `nib_ready` low until `gene_end`.

## Timing
- Reset values:
  - State `IDLE`; `ptr`=0, `ncnt`=0.
  - Outputs `we_wr`=0, `addr_wr`=0, `din_wr`=0, `done_wr`=0, `len_err`=0, `codon_cnt`=0.
  - `nib_ready`=0, `full`=0.
- Write latency: `we_wr`/`addr_wr`/`din_wr` are valid the cycle after the accepting edge (or the cycle after the `TERM`/`FIN` edge); `we_wr` is 1 for exactly one cycle per write.
- Throughput: one nibble per cycle. A codon of n nibbles takes n+1 cycles, because `TERM` inserts one bubble with `nib_ready`=0.
- `done_wr` rises the cycle after the final-`F` write is presented.
- `nib_ready` and `full` are combinational from registered state; accept is sampled at the rising edge.
- Simultaneous accept and `gene_end`: the nibble wins; `gene_end` is evaluated on a later non-accept cycle.
- `start` during `TERM`/`FIN`: the pending write is abandoned and `we_wr` is 0 next cycle.
- Asynchronous `rst` mid-write forces all reset values immediately; `we_wr` drops without waiting for a clock.

## Test plan
- `start`; codons {1,2,3} and {A,B} with `nib_last`; then `gene_end` -> RAM[0..7]=1,2,3,F,A,B,F,F; `codon_cnt`=2; `done_wr`=1; exactly 8 `we_wr` pulses.
- Six nibbles 1..6 with no `nib_last`, then `nib_valid`=0, `gene_end` -> RAM=1,2,3,4,5,F,6,F,F; `len_err`=1; `nib_ready` low for 1 cycle after nibble 5.
- Nibble F mid-codon ({7,F}) and a leading F -> RAM=7,F; the leading F is dropped with no write; `gene_end` mid-codon ({9}) -> 9,F,F.
- `ADDR_W`=5, continuous 1-nibble codons -> `full`=1 with `nib_ready`=0 at `ptr`=30 (after codons at 0..29, pairs ending at 29 — last data at 28, F at 29, next data blocked); `gene_end` -> final F; `addr_wr` never exceeds 31.
- Continuous nibble stream with a `start` pulse inserted during `TERM` -> no F written; next write at `addr_wr`=0; `codon_cnt`=0.
- `rst` low asynchronously mid-codon with `we_wr`=1 -> all outputs at reset values before the next edge; after release `nib_ready` stays 0 until `start`.
